// File: rtl/pragmatic_mac_stream.sv
// Essential-bit dot-product engine: per-lane signed power-of-two terms, adder tree,
// multi-beat accumulation, optional max-pool against result_prev, saturated output.
module pragmatic_mac_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 8,
  parameter int SHIFT_WIDTH  = 3,
  parameter int ACC_WIDTH    = 32,
  parameter int RESULT_WIDTH = 16,
  parameter int OUT_SHIFT    = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]     act,
  input  logic [VEC_LENGTH*SHIFT_WIDTH-1:0]    w_shift,
  input  logic [VEC_LENGTH-1:0]                w_en,
  input  logic [VEC_LENGTH-1:0]                w_neg,
  input  logic                                 in_last,
  input  logic                                 load_accum,
  input  logic                                 is_pooling,
  input  logic signed [RESULT_WIDTH-1:0]       result_prev,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [RESULT_WIDTH-1:0]       result
);

  localparam int LANE_W = DATA_WIDTH + 2**SHIFT_WIDTH;
  localparam int LOG2_V = $clog2(VEC_LENGTH);
  localparam int SUM_W  = LANE_W + LOG2_V;
  localparam int NODES  = 2*VEC_LENGTH - 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_ACCEPT, ST_DRAIN, ST_HOLD} state_t;

  state_t                          r_state, w_state_next;
  logic                            w_accept;
  logic                            w_out_hs;
  logic signed [LANE_W-1:0]        w_term [VEC_LENGTH];
  logic signed [SUM_W-1:0]         w_node [NODES];
  logic signed [ACC_WIDTH-1:0]     w_psum;
  logic signed [ACC_WIDTH-1:0]     w_init;
  logic signed [ACC_WIDTH-1:0]     w_shr;
  logic signed [RESULT_WIDTH-1:0]  w_sat;
  logic signed [RESULT_WIDTH-1:0]  w_res;

  logic                            r_first_pend;
  logic                            r_s1_valid, r_s1_first, r_s1_last;
  logic signed [ACC_WIDTH-1:0]     r_s1_psum;
  logic signed [ACC_WIDTH-1:0]     r_init;
  logic                            r_mode_pool;
  logic signed [RESULT_WIDTH-1:0]  r_prev_q;
  logic signed [ACC_WIDTH-1:0]     r_acc;
  logic                            r_s2_last;
  logic                            r_out_valid;
  logic signed [RESULT_WIDTH-1:0]  r_result;

  assign in_ready  = (r_state == ST_ACCEPT) && !reset;
  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = r_out_valid && out_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

  // Sign-extend before negating so the most negative activation negates cleanly.
  for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
    logic signed [DATA_WIDTH:0] w_ext, w_sgn;
    assign w_ext = {act[(gi+1)*DATA_WIDTH-1], act[gi*DATA_WIDTH +: DATA_WIDTH]};
    assign w_sgn = w_neg[gi] ? -w_ext : w_ext;
    assign w_term[gi] = w_en[gi]
      ? ({{(LANE_W-DATA_WIDTH-1){w_sgn[DATA_WIDTH]}}, w_sgn} <<< w_shift[gi*SHIFT_WIDTH +: SHIFT_WIDTH])
      : '0;
  end

  // Heap-ordered pairwise tree: leaves at [V-1 .. 2V-2], root at [0].
  always_comb begin
    for (int i = 0; i < NODES; i++) w_node[i] = '0;
    for (int i = 0; i < VEC_LENGTH; i++)
      w_node[VEC_LENGTH-1+i] = {{(SUM_W-LANE_W){w_term[i][LANE_W-1]}}, w_term[i]};
    for (int i = VEC_LENGTH-2; i >= 0; i--)
      w_node[i] = w_node[2*i+1] + w_node[2*i+2];
  end

  assign w_psum = {{(ACC_WIDTH-SUM_W){w_node[0][SUM_W-1]}}, w_node[0]};
  assign w_init = load_accum
    ? ({{(ACC_WIDTH-RESULT_WIDTH){result_prev[RESULT_WIDTH-1]}}, result_prev} <<< OUT_SHIFT)
    : '0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACCEPT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCEPT: if (w_accept && in_last) w_state_next = ST_DRAIN;
      ST_DRAIN:  if (r_s2_last)           w_state_next = ST_HOLD;
      ST_HOLD:   if (w_out_hs)            w_state_next = ST_ACCEPT;
      default:                            w_state_next = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_first_pend <= 1'b1;
      r_s1_valid   <= 1'b0;
      r_s1_first   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_psum    <= '0;
      r_init       <= '0;
      r_mode_pool  <= 1'b0;
      r_prev_q     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_first_pend <= 1'b0;
        r_s1_first   <= r_first_pend;
        r_s1_last    <= in_last;
        r_s1_psum    <= w_psum;
        if (r_first_pend) begin
          r_init      <= w_init;
          r_mode_pool <= is_pooling;
          r_prev_q    <= result_prev;
        end
      end else if (w_out_hs) begin
        r_first_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_s2_last <= 1'b0;
    end else begin
      r_s2_last <= r_s1_valid && r_s1_last;
      if (r_s1_valid) r_acc <= (r_s1_first ? r_init : r_acc) + r_s1_psum;
    end
  end

  assign w_shr = r_acc >>> OUT_SHIFT;
  assign w_sat = (w_shr > SAT_MAX) ? SAT_MAX[RESULT_WIDTH-1:0] :
                 (w_shr < SAT_MIN) ? SAT_MIN[RESULT_WIDTH-1:0] :
                                     w_shr[RESULT_WIDTH-1:0];
  assign w_res = (r_mode_pool && (r_prev_q > w_sat)) ? r_prev_q : w_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (r_s2_last) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pragmatic_mac_stream.sv
// Directed bench for pragmatic_mac_stream; expected results come from a behavioural
// model and are queued at stimulus time, then popped when the result is consumed.
module tb_pragmatic_mac_stream;
  localparam int DW = 8;
  localparam int VL = 8;
  localparam int SW = 3;
  localparam int RW = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [VL*DW-1:0]      act;
  logic [VL*SW-1:0]      w_shift;
  logic [VL-1:0]         w_en;
  logic [VL-1:0]         w_neg;
  logic                  in_last;
  logic                  load_accum;
  logic                  is_pooling;
  logic signed [RW-1:0]  result_prev;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [RW-1:0]  result;

  pragmatic_mac_stream dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .w_shift(w_shift), .w_en(w_en), .w_neg(w_neg),
    .in_last(in_last), .load_accum(load_accum), .is_pooling(is_pooling),
    .result_prev(result_prev), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  int     n_pass  = 0;
  int     n_total = 0;
  longint exp_q[$];
  int     b_act[VL], b_shift[VL], b_en[VL], b_neg[VL];
  longint m_acc;
  longint m_prev;
  bit     m_pool;
  bit     m_first;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_uniform(input int a, input int sh, input int en, input int ng);
    for (int i = 0; i < VL; i++) begin
      b_act[i] = a; b_shift[i] = sh; b_en[i] = en; b_neg[i] = ng;
    end
  endtask

  task automatic set_lane0(input int a, input int sh, input int ng);
    set_uniform(0, 0, 0, 0);
    b_act[0] = a; b_shift[0] = sh; b_en[0] = 1; b_neg[0] = ng;
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < VL; i++) begin
      act[i*DW +: DW]     = b_act[i][DW-1:0];
      w_shift[i*SW +: SW] = b_shift[i][SW-1:0];
      w_en[i]             = b_en[i][0];
      w_neg[i]            = b_neg[i][0];
    end
  endtask

  function automatic longint beat_psum();
    longint s = 0;
    longint t;
    for (int i = 0; i < VL; i++) begin
      if (b_en[i] != 0) begin
        t = longint'(b_act[i]) * (longint'(1) << b_shift[i]);
        if (b_neg[i] != 0) t = -t;
        s += t;
      end
    end
    return s;
  endfunction

  function automatic longint job_result(input longint acc, input bit pool, input longint prev);
    longint sat;
    sat = acc;
    if (sat > 32767)  sat = 32767;
    if (sat < -32768) sat = -32768;
    if (pool && prev > sat) sat = prev;
    return sat;
  endfunction

  task automatic send_beat(input bit last, input bit load, input bit pool, input int prev);
    int cnt = 0;
    drive_lanes();
    in_last = last; load_accum = load; is_pooling = pool; result_prev = prev[RW-1:0];
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    if (cnt >= 50) begin
      check("accept_timeout", cnt, 0);
    end else begin
      @(posedge clk); #1;
      if (m_first) begin
        m_acc = load ? longint'(prev) : 0;
        m_pool = pool; m_prev = prev; m_first = 0;
      end
      m_acc += beat_psum();
      if (last) exp_q.push_back(job_result(m_acc, m_pool, m_prev));
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out();
    int cnt = 0;
    while (out_valid !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    if (cnt >= 50) check("out_valid_timeout", cnt, 0);
  endtask

  task automatic recv(input string tag);
    out_ready = 1'b1;
    wait_out();
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) check("scoreboard_size", exp_q.size(), 1);
      else                   check(tag, result, exp_q.pop_front());
      @(posedge clk); #1;
      m_first = 1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    load_accum = 1'b0; is_pooling = 1'b0; result_prev = '0;
    act = '0; w_shift = '0; w_en = '0; w_neg = '0;
    m_first = 1; m_acc = 0; m_pool = 0; m_prev = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single beat with latency checks: out_valid must rise two edges after acceptance.
    set_uniform(3, 2, 1, 0);
    send_beat(1, 0, 0, 0);
    check("lat_e0_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("lat_e1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("lat_e2_out_valid", out_valid, 1);
    recv("single_beat");

    // Two-beat job.
    set_lane0(5, 3, 0);
    send_beat(0, 0, 0, 0);
    check("mid_job_in_ready", in_ready, 1);
    set_lane0(5, 0, 1);
    send_beat(1, 0, 0, 0);
    check("after_last_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_in_ready", in_ready, 0);
    recv("two_beat");
    check("post_hs_in_ready", in_ready, 1);

    // Saturation both directions.
    set_uniform(-128, 7, 1, 1);
    send_beat(1, 0, 0, 0);
    recv("sat_pos");
    set_uniform(-128, 7, 1, 0);
    send_beat(1, 0, 0, 0);
    recv("sat_neg");

    // Load and pooling.
    set_lane0(1, 0, 1);
    send_beat(1, 1, 0, 100);
    recv("load_accum");
    set_uniform(3, 2, 1, 0);
    send_beat(1, 0, 1, 500);
    recv("pool_prev_wins");
    send_beat(1, 0, 1, -5);
    recv("pool_sum_wins");

    // Back-pressure: result held, pending beat not consumed.
    send_beat(1, 0, 0, 0);
    wait_out();
    set_uniform(2, 1, 1, 0);
    drive_lanes();
    in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (exp_q.size() != 0) check("bp_result_stable", result, exp_q[0]);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    recv("bp_release");
    send_beat(1, 0, 0, 0);
    recv("bp_next_first");

    // Reset in the middle of a job.
    set_uniform(3, 2, 1, 0);
    send_beat(0, 0, 0, 0);
    send_beat(0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    reset = 1'b0;
    m_first = 1;
    @(posedge clk); #1;
    check("midrst_after_out_valid", out_valid, 0);
    set_uniform(2, 1, 1, 0);
    send_beat(1, 0, 0, 0);
    recv("midrst_clean_job");
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
